// File: rtl/butterfly_pkg.sv
// Purpose : shared constants and types for the FFT butterfly output crossbar.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package butterfly_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int LANES          = 4;          // lanes per write-back word
    localparam int TOTAL_LANES    = 2 * LANES;  // lanes across both words

    typedef enum logic [1:0] {
        MODE_S1,
        MODE_S2,
        MODE_WIDE,
        MODE_INVALID
    } stride_mode_e;

    // Memory lane positions; 0..3 land in word1, 4..7 in word2.
    localparam int LANE_0 = 0;
    localparam int LANE_1 = 1;
    localparam int LANE_2 = 2;
    localparam int LANE_3 = 3;
    localparam int LANE_4 = 4;
    localparam int LANE_5 = 5;
    localparam int LANE_6 = 6;
    localparam int LANE_7 = 7;

endpackage

// File: rtl/butterfly_stride_decode.sv
// Purpose : classify the FFT stage stride into a crossbar mode.
// Latency : combinational.
// Backpressure: none.
// Ports: i_STRIDE (10b stage stride) -> o_MODE (stride_mode_e).
//   1 -> S1, 2 -> S2, >=4 -> WIDE, 0 or 3 -> INVALID.
module butterfly_stride_decode
    import butterfly_pkg::*;
(
    input  logic [9:0]   i_STRIDE,
    output stride_mode_e o_MODE
);

    always_comb begin
        o_MODE = MODE_INVALID;
        if (i_STRIDE == 10'd1) begin
            o_MODE = MODE_S1;
        end else if (i_STRIDE == 10'd2) begin
            o_MODE = MODE_S2;
        end else if (i_STRIDE >= 10'd4) begin
            // Any stride of 4 or more pairs lane j with lane j+4 within an 8-lane row.
            o_MODE = MODE_WIDE;
        end
    end

endmodule

// File: rtl/butterfly_xbar_out.sv
// Purpose : reorder 4 butterflies' top/bottom results into two 4-lane memory words.
// Latency : 1 cycle (mux result and valid registered every edge).
// Backpressure: none; data registers load every cycle, downstream qualifies with o_VALID.
// Ports: i_CLK, i_RESET (sync, active-high), i_VALID, i_STRIDE[9:0],
//   i_BUTTERFLY_{1..4}_{TOP,BOTTOM}[DATA_W-1:0] in; o_VALID, o_READ_OUTPUT1 (lanes 0-3),
//   o_READ_OUTPUT2 (lanes 4-7) out. Lane 0 is the LSBs of word1.
// Optional: define BUTTERFLY_XBAR_OUT_STRIDE_ERR_EN to add o_STRIDE_ERR, a registered flag
//   raised for valid samples carrying an unusable stride (0 or 3).
module butterfly_xbar_out
    import butterfly_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                  i_CLK,
    input  logic                  i_RESET,
    input  logic                  i_VALID,
    input  logic [9:0]            i_STRIDE,
    input  logic [DATA_W-1:0]     i_BUTTERFLY_1_TOP,
    input  logic [DATA_W-1:0]     i_BUTTERFLY_2_TOP,
    input  logic [DATA_W-1:0]     i_BUTTERFLY_3_TOP,
    input  logic [DATA_W-1:0]     i_BUTTERFLY_4_TOP,
    input  logic [DATA_W-1:0]     i_BUTTERFLY_1_BOTTOM,
    input  logic [DATA_W-1:0]     i_BUTTERFLY_2_BOTTOM,
    input  logic [DATA_W-1:0]     i_BUTTERFLY_3_BOTTOM,
    input  logic [DATA_W-1:0]     i_BUTTERFLY_4_BOTTOM,
    output logic                  o_VALID,
`ifdef BUTTERFLY_XBAR_OUT_STRIDE_ERR_EN
    output logic                  o_STRIDE_ERR,
`endif
    output logic [LANES*DATA_W-1:0] o_READ_OUTPUT1,
    output logic [LANES*DATA_W-1:0] o_READ_OUTPUT2
);

    stride_mode_e mode;

    logic [DATA_W-1:0] top  [LANES];
    logic [DATA_W-1:0] bot  [LANES];
    logic [DATA_W-1:0] lane [TOTAL_LANES];

    logic [LANES*DATA_W-1:0] word1_nxt;
    logic [LANES*DATA_W-1:0] word2_nxt;

    butterfly_stride_decode u_decode (
        .i_STRIDE (i_STRIDE),
        .o_MODE   (mode)
    );

    assign top[0] = i_BUTTERFLY_1_TOP;
    assign top[1] = i_BUTTERFLY_2_TOP;
    assign top[2] = i_BUTTERFLY_3_TOP;
    assign top[3] = i_BUTTERFLY_4_TOP;
    assign bot[0] = i_BUTTERFLY_1_BOTTOM;
    assign bot[1] = i_BUTTERFLY_2_BOTTOM;
    assign bot[2] = i_BUTTERFLY_3_BOTTOM;
    assign bot[3] = i_BUTTERFLY_4_BOTTOM;

    // Lane crossbar. INVALID keeps the all-zero default so the output is never X.
    always_comb begin
        for (int n = 0; n < TOTAL_LANES; n++) begin
            lane[n] = '0;
        end
        case (mode)
            MODE_S1: begin
                lane[LANE_0] = top[0];
                lane[LANE_1] = bot[0];
                lane[LANE_2] = top[1];
                lane[LANE_3] = bot[1];
                lane[LANE_4] = top[2];
                lane[LANE_5] = bot[2];
                lane[LANE_6] = top[3];
                lane[LANE_7] = bot[3];
            end
            MODE_S2: begin
                lane[LANE_0] = top[0];
                lane[LANE_1] = top[1];
                lane[LANE_2] = bot[0];
                lane[LANE_3] = bot[1];
                lane[LANE_4] = top[2];
                lane[LANE_5] = top[3];
                lane[LANE_6] = bot[2];
                lane[LANE_7] = bot[3];
            end
            MODE_WIDE: begin
                lane[LANE_0] = top[0];
                lane[LANE_1] = top[1];
                lane[LANE_2] = top[2];
                lane[LANE_3] = top[3];
                lane[LANE_4] = bot[0];
                lane[LANE_5] = bot[1];
                lane[LANE_6] = bot[2];
                lane[LANE_7] = bot[3];
            end
            default: ;
        endcase
    end

    always_comb begin
        word1_nxt = '0;
        word2_nxt = '0;
        for (int n = 0; n < LANES; n++) begin
            word1_nxt[n*DATA_W +: DATA_W] = lane[n];
            word2_nxt[n*DATA_W +: DATA_W] = lane[n + LANES];
        end
    end

    // Reset wins over the load, so a sample in flight during reset is dropped.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            o_VALID        <= 1'b0;
            o_READ_OUTPUT1 <= '0;
            o_READ_OUTPUT2 <= '0;
        end else begin
            o_VALID        <= i_VALID;
            o_READ_OUTPUT1 <= word1_nxt;
            o_READ_OUTPUT2 <= word2_nxt;
        end
    end

`ifdef BUTTERFLY_XBAR_OUT_STRIDE_ERR_EN
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            o_STRIDE_ERR <= 1'b0;
        end else begin
            o_STRIDE_ERR <= i_VALID && (mode == MODE_INVALID);
        end
    end
`endif

endmodule

// File: tb/tb_butterfly_xbar_out.sv
// Purpose : self-checking bench for butterfly_xbar_out with a lane-placement reference model.
// Latency : expects every output one edge after the inputs that produced it.
// Backpressure: none; one expected entry is queued per rising edge and checked on the falling edge.
module tb_butterfly_xbar_out;

    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          vld;
    logic [9:0]    stride;
    logic [DW-1:0] t [4];
    logic [DW-1:0] b [4];

    logic            o_vld;
    logic [4*DW-1:0] o_w1;
    logic [4*DW-1:0] o_w2;
`ifdef BUTTERFLY_XBAR_OUT_STRIDE_ERR_EN
    logic            o_err;
`endif

    int checks = 0;
    int errors = 0;

    butterfly_xbar_out #(.DATA_W(DW)) dut (
        .i_CLK                (clk),
        .i_RESET              (rst),
        .i_VALID              (vld),
        .i_STRIDE             (stride),
        .i_BUTTERFLY_1_TOP    (t[0]),
        .i_BUTTERFLY_2_TOP    (t[1]),
        .i_BUTTERFLY_3_TOP    (t[2]),
        .i_BUTTERFLY_4_TOP    (t[3]),
        .i_BUTTERFLY_1_BOTTOM (b[0]),
        .i_BUTTERFLY_2_BOTTOM (b[1]),
        .i_BUTTERFLY_3_BOTTOM (b[2]),
        .i_BUTTERFLY_4_BOTTOM (b[3]),
        .o_VALID              (o_vld),
`ifdef BUTTERFLY_XBAR_OUT_STRIDE_ERR_EN
        .o_STRIDE_ERR         (o_err),
`endif
        .o_READ_OUTPUT1       (o_w1),
        .o_READ_OUTPUT2       (o_w2)
    );

    typedef struct {
        logic            v;
        logic            err;
        logic [4*DW-1:0] w1;
        logic [4*DW-1:0] w2;
    } exp_t;

    exp_t exp_q [$];

    // Reference model: butterfly k works on the pair (p, p+s) of an 8-point row, where
    // p = (k / s) * 2s + (k % s) and s is the effective stride (1, 2, or 4 for anything wider).
    always @(posedge clk) begin : model
        exp_t e;
        int   s;
        int   p;
        e.v   = 1'b0;
        e.err = 1'b0;
        e.w1  = '0;
        e.w2  = '0;
        if (!rst) begin
            e.v = vld;
            if (stride == 10'd1)      s = 1;
            else if (stride == 10'd2) s = 2;
            else if (stride >= 10'd4) s = 4;
            else                      s = 0;
            if (s == 0) begin
                e.err = vld;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    p = (k / s) * 2 * s + (k % s);
                    if (p < 4) e.w1[p*DW +: DW] = t[k];
                    else       e.w2[(p-4)*DW +: DW] = t[k];
                    if (p + s < 4) e.w1[(p+s)*DW +: DW] = b[k];
                    else           e.w2[(p+s-4)*DW +: DW] = b[k];
                end
            end
        end
        exp_q.push_back(e);
    end

    task automatic chk(input string name, input logic [4*DW-1:0] act, input logic [4*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("o_VALID", {127'd0, o_vld}, {127'd0, e.v});
            chk("word1",   o_w1, e.w1);
            chk("word2",   o_w2, e.w2);
`ifdef BUTTERFLY_XBAR_OUT_STRIDE_ERR_EN
            chk("o_STRIDE_ERR", {127'd0, o_err}, {127'd0, e.err});
`endif
        end
    end

    task automatic set_fixed();
        t[0] = 32'h11111111; t[1] = 32'h22222222; t[2] = 32'h33333333; t[3] = 32'h44444444;
        b[0] = 32'hAAAAAAAA; b[1] = 32'hBBBBBBBB; b[2] = 32'hCCCCCCCC; b[3] = 32'hDDDDDDDD;
    endtask

    task automatic set_rand();
        for (int k = 0; k < 4; k++) begin
            t[k] = $urandom;
            b[k] = $urandom;
        end
    endtask

    // Apply one cycle of inputs, then advance past the next rising edge.
    task automatic cyc(input logic r, input logic v, input logic [9:0] s);
        rst    = r;
        vld    = v;
        stride = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; vld = 1'b0; stride = 10'd0;
        set_rand();

        // Reset held with random inputs.
        cyc(1'b1, 1'b1, 10'd8);
        set_rand();
        cyc(1'b1, 1'b1, 10'd1);

        // Directed mappings with the reference data pattern.
        set_fixed();
        cyc(1'b0, 1'b1, 10'd8);
        cyc(1'b0, 1'b1, 10'd4);
        cyc(1'b0, 1'b1, 10'd512);
        cyc(1'b0, 1'b1, 10'd2);
        cyc(1'b0, 1'b1, 10'd1);
        cyc(1'b0, 1'b1, 10'd0);
        cyc(1'b0, 1'b1, 10'd3);
        cyc(1'b0, 1'b0, 10'd0);
        cyc(1'b0, 1'b0, 10'd3);
        cyc(1'b0, 1'b0, 10'd8);
        cyc(1'b0, 1'b1, 10'd1023);

        // Back-to-back strides with toggling valid and a reset in the third cycle.
        set_rand(); cyc(1'b0, 1'b1, 10'd8);
        set_rand(); cyc(1'b0, 1'b0, 10'd2);
        set_rand(); cyc(1'b1, 1'b1, 10'd1);
        set_rand(); cyc(1'b0, 1'b0, 10'd0);
        set_rand(); cyc(1'b0, 1'b1, 10'd2);

        // Randomized traffic with stride biased toward the decode boundaries.
        for (int i = 0; i < 400; i++) begin
            logic [9:0] s;
            case ($urandom_range(0, 6))
                0:       s = 10'd0;
                1:       s = 10'd1;
                2:       s = 10'd2;
                3:       s = 10'd3;
                4:       s = 10'd4;
                5:       s = 10'(1 << $urandom_range(3, 9));
                default: s = 10'($urandom_range(0, 1023));
            endcase
            set_rand();
            cyc(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), s);
        end

        rst = 1'b0; vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/butterfly_xbar_out.md
Name: butterfly_xbar_out

Overview:
Output-side crossbar of the radix-2 FFT datapath. It takes the top/bottom results of four parallel butterfly units (8 x 32-bit values) and reorders them by the current stage stride into memory order. The result is two 128-bit write-back words, each holding 4 lanes. The block sits between the butterfly array and the data SRAM write port, with one registered output stage.

Parameters:
DATA_W, 32, width of one complex/packed sample lane; each read word is 4*DATA_W bits.

Ports:
i_CLK  input  1  clock, all state on rising edge.
i_RESET  input  1  synchronous active-high reset.
i_VALID  input  1  butterfly results valid this cycle.
i_STRIDE  input  10  current FFT stage stride (distance between butterfly operand pair).
i_BUTTERFLY_1_TOP … i_BUTTERFLY_4_TOP  input  DATA_W each  top outputs of butterflies 1-4.
i_BUTTERFLY_1_BOTTOM … i_BUTTERFLY_4_BOTTOM  input  DATA_W each  bottom outputs of butterflies 1-4.
o_VALID  output  1  registered i_VALID.
o_READ_OUTPUT1  output  4*DATA_W  write-back word for memory lanes 0-3.
o_READ_OUTPUT2  output  4*DATA_W  write-back word for memory lanes 4-7.

Behaviour:
- Lane numbering: lanes 0-7; lane n of word1 occupies bits [n*DATA_W +: DATA_W], n=0..3; lanes 4-7 map to word2 the same way. Lane 0 is the LSBs.
- Notation: Tk/Bk = top/bottom of butterfly k.
- Stride decode (combinational):
  - stride==1 gives mode S1.
  - stride==2 gives mode S2.
  - stride>=4 gives mode WIDE.
  - stride==0 or 3 gives mode INVALID.
- Mode S1 (pairs 0/1, 2/3, 4/5, 6/7): lanes 0..7 = T1,B1,T2,B2,T3,B3,T4,B4.
- Mode S2 (pairs 0/2, 1/3, 4/6, 5/7): lanes 0..7 = T1,T2,B1,B2,T3,T4,B3,B4.
- Mode WIDE (pairs j/j+4): lanes 0..7 = T1,T2,T3,T4,B1,B2,B3,B4.
- Mode INVALID: both words are all-zero.
- Latency: exactly 1 cycle. Mux result and i_VALID are registered on every rising edge; outputs depend only on the registers.
- When i_VALID=0, data registers still load (no hold). Downstream qualifies data with o_VALID.
- Reset: on rising edge with i_RESET=1, o_VALID=0, o_READ_OUTPUT1=0, o_READ_OUTPUT2=0. Reset has priority over the load.
- Reset mid-stream: the in-flight sample is dropped. Normal loading resumes on the first edge with i_RESET=0.
- Stride changes take effect on the next edge; there is no stride pipelining beyond the output register.
- No X-propagation on INVALID: the output is a defined zero.

Optional Feature:
Macro BUTTERFLY_XBAR_OUT_STRIDE_ERR_EN.
- Defined: adds output o_STRIDE_ERR (1 bit, registered, reset 0). It is set to i_VALID & (mode==INVALID) with the same 1-cycle latency as the data.
- Undefined: the port and its logic do not exist; all other behaviour is identical.

Decomposition:
- Package butterfly_pkg: DATA_W default constant, LANES=4 constant, stride_mode_e enum {MODE_S1, MODE_S2, MODE_WIDE, MODE_INVALID}, and lane index constants.
- One sub-module, butterfly_stride_decode: maps i_STRIDE (10b) to stride_mode_e, purely combinational.
- Lane muxing and output registers stay in the top level.

Test Plan:
- Reset: hold i_RESET=1 for 2 cycles with random inputs -> o_VALID=0 and both outputs 0. Release, then first loaded value appears 1 cycle later.
- WIDE: stride=8, T1..T4=11111111,22222222,33333333,44444444 and B1..B4=AAAAAAAA,BBBBBBBB,CCCCCCCC,DDDDDDDD, i_VALID=1 -> next cycle word1=44444444_33333333_22222222_11111111, word2=DDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, o_VALID=1. Repeat with stride=4 and 512 for the same result.
- S2: same data, stride=2 -> word1=BBBBBBBB_AAAAAAAA_22222222_11111111, word2=DDDDDDDD_CCCCCCCC_44444444_33333333.
- S1: same data, stride=1 -> word1=BBBBBBBB_22222222_AAAAAAAA_11111111, word2=DDDDDDDD_44444444_CCCCCCCC_33333333.
- INVALID: stride=0, then 3 -> both words 0. With BUTTERFLY_XBAR_OUT_STRIDE_ERR_EN, o_STRIDE_ERR=1 when i_VALID=1 and 0 when i_VALID=0.
- Back-to-back: stride sequence 8,2,1,0 on consecutive cycles with i_VALID toggling, plus i_RESET asserted in cycle 3 -> each output matches the prior-cycle mapping, and the cycle after reset is all-zero with o_VALID=0.
